// File: rtl/alu_operand_loader.sv
// Operand loader for the board-level ALU: three debounced push-buttons sequence
// the capture of operand A, operand B and the opcode from a shared switch bank.

module alu_operand_loader_btn #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d, s2_q, s2_d;
  logic          level_q, level_d, level_dly_q, level_dly_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    s1_d        = btn;
    s2_d        = s1_q;
    level_d     = level_q;
    cnt_d       = '0;
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      cnt_q       <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

module alu_operand_loader #(
  parameter int N_BITS          = 6,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_sw,
  input  logic              i_btn_a,
  input  logic              i_btn_b,
  input  logic              i_btn_op,
  output logic [N_BITS-1:0] o_A,
  output logic [N_BITS-1:0] o_B,
  output logic [N_BITS-1:0] o_OP,
  output logic              o_ready,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_DONE = 2'b11
  } state_t;

  logic press_a, press_b, press_op;

  alu_operand_loader_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_a (
    .clock(clock), .reset(reset), .btn(i_btn_a), .press(press_a)
  );
  alu_operand_loader_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_b (
    .clock(clock), .reset(reset), .btn(i_btn_b), .press(press_b)
  );
  alu_operand_loader_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_op (
    .clock(clock), .reset(reset), .btn(i_btn_op), .press(press_op)
  );

  state_t            state_q, state_d;
  logic [N_BITS-1:0] a_q, a_d, b_q, b_d, op_q, op_d;
  logic              ready_q, ready_d;

  // In S_DONE any operand may be reloaded; A restarts the sequence, and only one press acts per cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      S_A: if (press_a) begin
        a_d     = i_sw;
        state_d = S_B;
      end
      S_B: if (press_b) begin
        b_d     = i_sw;
        state_d = S_OP;
      end
      S_OP: if (press_op) begin
        op_d    = i_sw;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (press_a) begin
          a_d     = i_sw;
          state_d = S_B;
        end else if (press_b) begin
          b_d = i_sw;
        end else if (press_op) begin
          op_d = i_sw;
        end
      end
      default: state_d = S_A;
    endcase
    ready_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      ready_q <= ready_d;
    end
  end

  assign o_A     = a_q;
  assign o_B     = b_q;
  assign o_OP    = op_q;
  assign o_ready = ready_q;
  assign o_state = state_q;

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream stage of the board-level ALU datapath.
- Captures operand A, operand B and the 6-bit opcode from one shared bank of slide switches, using three push-buttons.
- Each button is synchronised, debounced and edge-detected. A sequencing FSM then loads the registered i_A / i_B / i_OP that the ALU consumes.
- Asserts o_ready once a complete operand set is held.

Parameters:
- N_BITS, 6, width of switch bank, o_A, o_B and o_OP.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level change is accepted. Must be ≥2. Bench overrides it to 4.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_sw  input  N_BITS  slide switches; sampled directly when a load occurs (quasi-static, not synchronised).
- i_btn_a  input  1  raw button, load A.
- i_btn_b  input  1  raw button, load B.
- i_btn_op  input  1  raw button, load opcode.
- o_A  output  N_BITS  registered operand A, to ALU i_A.
- o_B  output  N_BITS  registered operand B, to ALU i_B.
- o_OP  output  N_BITS  registered opcode, to ALU i_OP.
- o_ready  output  1  high while the FSM is in S_DONE.
- o_state  output  2  current FSM state encoding, for debug LEDs.

Behaviour:
- Reset: reset high at a rising edge forces the following to 0 on that edge:
  - o_A, o_B, o_OP, o_ready;
  - all synchroniser flops, debounced levels, debounce counters and press pulses.
  - The FSM goes to S_A (o_state=2'b00).
  - Reset mid-sequence discards partially loaded operands.
- Button conditioning, per button, three identical instances:
  - Two-flop synchroniser produces s2.
  - Counter handling:
    - If s2 equals the debounced level, the counter clears to 0.
    - If s2 differs, the counter increments.
    - When the counter equals DEBOUNCE_CYCLES-1 and s2 still differs, the debounced level takes s2 and the counter clears.
  - press is a registered one-cycle pulse on the debounced rising edge. A falling edge produces nothing.
- Latency: let k be the first edge sampling the button high.
  - Debounced level goes high after edge k+1+DEBOUNCE_CYCLES.
  - press is high during the cycle after edge k+2+DEBOUNCE_CYCLES.
  - Target register updates at edge k+3+DEBOUNCE_CYCLES.
  - With DEBOUNCE_CYCLES=4, the load lands 7 edges after k.
- Glitch handling:
  - A level that reverts before DEBOUNCE_CYCLES consecutive differing cycles produces no press; the counter clears.
  - A held button produces exactly one press.
- FSM states: S_A=00, S_B=01, S_OP=10, S_DONE=11.
  - S_A: press_a loads o_A<=i_sw, then goes to S_B. Other presses are ignored.
  - S_B: press_b loads o_B<=i_sw, then goes to S_OP. Other presses are ignored.
  - S_OP: press_op loads o_OP<=i_sw, then goes to S_DONE. Other presses are ignored.
  - S_DONE, priority A > B > OP, one action per cycle; lower-priority simultaneous presses are dropped:
    - press_a loads o_A and goes to S_B.
    - otherwise press_b loads o_B and stays in S_DONE.
    - otherwise press_op loads o_OP and stays in S_DONE.
- Simultaneous presses outside S_DONE: only the press expected by the current state acts.
- o_ready is registered: it equals (state==S_DONE) with the same edge timing as o_state.
- Registers not addressed by an accepted press hold their value. Values persist across state changes until reset or reload.
- Button held through reset release: the debounced level starts at 0, so the button registers one press after the normal latency.
- No arithmetic inside the block. i_sw is copied bit-exact with no extension.

Test Plan:
1. Reset then sequence:
   - Stimulus: DEBOUNCE_CYCLES=4. Sequence sw=6'h05 + press A, sw=6'h03 + press B, sw=6'b100000 + press OP.
   - Required: o_A=5, o_B=3, o_OP=6'h20; o_ready=1; o_state=11.
   - Required: each load lands exactly 7 edges after the button is first sampled high.
2. Out-of-order presses:
   - Stimulus: in S_A, press B, then press OP.
   - Required: o_B and o_OP stay 0, state stays 00.
   - Stimulus: then press A with sw=6'h2A.
   - Required: o_A=6'h2A, state=01.
3. Bounce rejection:
   - Stimulus: i_btn_a toggles high 3 cycles / low 2 cycles ×5, then stays low.
   - Required: no load, counter back to 0.
   - Stimulus: then hold high 20 cycles.
   - Required: exactly one load.
4. S_DONE updates:
   - Stimulus: from a loaded set, press OP with sw=6'b100010.
   - Required: o_OP=6'h22, o_ready stays 1.
   - Stimulus: then press A.
   - Required: state=01, o_ready=0, o_B/o_OP retained.
5. Simultaneous in S_DONE:
   - Stimulus: A and B pressed on the same cycle, sw=6'h11.
   - Required: only o_A=6'h11, state=01; o_B unchanged.
6. Reset mid-operation:
   - Stimulus: in S_OP, assert reset 1 cycle while btn_b is held.
   - Required: all outputs 0, state=00; one press_b pulse after 7 edges, ignored in S_A.
